snitch_tcdm_bank_arb: RTL and testbench
=======================================

Name: snitch_tcdm_bank_arb

Overview:
- Per-bank arbiter and response sequencer for one TCDM SRAM bank.
- Shares the bank between NumReq requesters, e.g. the interconnect output for that bank and the DMA/accelerator ports.
- Round-robin with lock-in and starvation escalation; bank may back-pressure via mem_gnt_i.
- Tracks grants through a fixed-latency pipe and steers the read response to the owning requester.

Parameters:
- NumReq, 2, number of requesters (>=2).
- AddrWidth, 10, bank word-address width.
- DataWidth, 64, data width; StrbWidth = DataWidth/8.
- MemoryResponseLatency, 1, cycles from accepted bank request to valid mem_rdata_i (>=1).
- StarveLimit, 16, consecutive lost cycles before a requester gets absolute priority (>=2).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- req_valid_i  in  NumReq  request valid per requester.
- req_ready_o  out  NumReq  request accepted this cycle.
- req_addr_i  in  NumReq x AddrWidth  word address.
- req_write_i  in  NumReq  1 = write.
- req_wdata_i  in  NumReq x DataWidth  write data.
- req_strb_i  in  NumReq x StrbWidth  byte enables.
- rsp_valid_o  out  NumReq  response valid; one pulse per accepted request, reads and writes.
- rsp_rdata_o  out  DataWidth  read data, broadcast; qualified by rsp_valid_o.
- mem_req_o  out  1  bank request.
- mem_gnt_i  in  1  bank accepts request; may be low for scrub/refresh.
- mem_addr_o  out  AddrWidth  bank address.
- mem_we_o  out  1  write enable.
- mem_wdata_o  out  DataWidth  write data.
- mem_be_o  out  StrbWidth  byte enables.
- mem_rdata_i  in  DataWidth  read data, MemoryResponseLatency after accept.
- conflict_cnt_o  out  32  arbitration conflict cycles (optional feature).

Behaviour:
- Reset: all outputs 0, rr pointer 0, lock cleared, starve counters 0, response pipe invalid. Async assertion clears state immediately; in-flight responses are dropped, no rsp_valid_o after reset.
- Selection priority:
  1. Locked index, if lock is set.
  2. Lowest-index requester whose starve counter >= StarveLimit.
  3. Round-robin: first valid index >= rr pointer, wrapping.
- mem_req_o = |req_valid_i; mem_addr/we/wdata/be are muxed from the selected index.
- Accept = mem_req_o & mem_gnt_i. req_ready_o is one-hot at the selected index on accept, else 0. Purely combinational, zero-cycle grant.
- Lock-in: if mem_req_o and !mem_gnt_i, lock the selected index; the lock holds until that index is accepted. Requesters obey AXI valid/ready: valid and payload stay stable until ready.
- On accept of index k: rr pointer <= (k+1) mod NumReq; starve counter[k] <= 0.
- Starve counter[j], j != k: increments when req_valid_i[j] & !req_ready_o[j]; saturates at StarveLimit; cleared when j is accepted; holds when not valid.
- Escalation does not break an active lock.
- Response pipe: {valid, idx} shift register of depth MemoryResponseLatency.
  - Input valid = accept, idx = selected index.
  - rsp_valid_o[idx] = pipe-out valid; rsp_rdata_o = mem_rdata_i.
  - Throughput 1 request/cycle, latency exactly MemoryResponseLatency cycles. No response back-pressure.
- Simultaneous valid on all requesters with mem_gnt_i=1: strict rotation, each served once per NumReq cycles.
- rr pointer wraps from NumReq-1 to 0.

Optional Feature:
- Macro: SNITCH_TCDM_ARB_STATS_EN.
- Defined: conflict_cnt_o is a 32-bit counter. Increments each cycle with popcount(req_valid_i) >= 2 or (mem_req_o & !mem_gnt_i). Wraps at 2^32. Cleared by reset.
- Undefined: conflict_cnt_o tied to 0 and no counter flops.

Decomposition:
- Package snitch_tcdm_arb_pkg:
  - rsp_track_t struct {valid, idx}, idx width = cf_math_pkg::idx_width(NumReq).
  - Starve counter width $clog2(StarveLimit+1).
- Sub-module snitch_tcdm_arb_rsp_tracker: the response shift register, reset to invalid, parameterised on depth.

Test Plan:
- Single read: req 0 valid, addr 0x3, mem_gnt_i=1, latency 1 -> req_ready_o=01 in cycle 0; cycle 1 rsp_valid_o=01, rsp_rdata_o = mem_rdata_i.
- Round-robin: NumReq=2, both valid for 4 cycles -> grants 0,1,0,1; rsp_valid_o follows one cycle later in the same order.
- Lock-in: req 1 selected, mem_gnt_i=0 for 3 cycles, req 0 raised meanwhile -> ready stays 0. When mem_gnt_i rises, req 1 is accepted first and req 0 the next cycle.
- Starvation: NumReq=3, StarveLimit=2; req 0 and req 1 valid every cycle; req 2 valid with rr forced past it -> req 2 accepted by its 3rd waiting cycle.
- Latency 3: back-to-back accepts of idx 0,1,0 -> rsp_valid_o = 001, 010, 001 in cycles 3, 4, 5.
- Reset mid-flight: accept at cycle 0, latency 2, rst_i pulsed in cycle 1 -> no rsp_valid_o, outputs 0; with SNITCH_TCDM_ARB_STATS_EN, conflict_cnt_o = 0.

Source files
------------

// File: rtl/snitch_tcdm_arb_pkg.sv
// Shared types and sizing helpers for the TCDM bank arbiter.
package snitch_tcdm_arb_pkg;

  // The track entry carries a fixed-width index so the type can live here; the
  // arbiter uses the low idx_width(NumReq) bits and compares the full field.
  localparam int unsigned MaxIdxWidth = 8;

  function automatic int unsigned idx_width(input int unsigned num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

  function automatic int unsigned starve_width(input int unsigned limit);
    return $clog2(limit + 1);
  endfunction

  typedef struct packed {
    logic                   valid;
    logic [MaxIdxWidth-1:0] idx;
  } rsp_track_t;

endpackage

// File: rtl/snitch_tcdm_arb_rsp_tracker.sv
// Fixed-depth shift register that remembers which requester owns each in-flight bank access.
module snitch_tcdm_arb_rsp_tracker
  import snitch_tcdm_arb_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  rsp_track_t in_i,
  output rsp_track_t out_o
);

  rsp_track_t [Depth-1:0] pipe_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= in_i;
      for (int unsigned i = 1; i < Depth; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign out_o = pipe_q[Depth-1];

endmodule

// File: rtl/snitch_tcdm_bank_arb.sv
// Per-bank round-robin arbiter with lock-in, starvation escalation and response steering.
// Define SNITCH_TCDM_ARB_STATS_EN to enable the conflict_cnt_o statistics counter.
module snitch_tcdm_bank_arb
  import snitch_tcdm_arb_pkg::*;
#(
  parameter  int unsigned NumReq                = 2,
  parameter  int unsigned AddrWidth             = 10,
  parameter  int unsigned DataWidth             = 64,
  parameter  int unsigned MemoryResponseLatency = 1,
  parameter  int unsigned StarveLimit           = 16,
  localparam int unsigned StrbWidth             = DataWidth / 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumReq-1:0]                req_valid_i,
  output logic [NumReq-1:0]                req_ready_o,
  input  logic [NumReq-1:0][AddrWidth-1:0] req_addr_i,
  input  logic [NumReq-1:0]                req_write_i,
  input  logic [NumReq-1:0][DataWidth-1:0] req_wdata_i,
  input  logic [NumReq-1:0][StrbWidth-1:0] req_strb_i,
  output logic [NumReq-1:0]                rsp_valid_o,
  output logic [DataWidth-1:0]             rsp_rdata_o,
  output logic                             mem_req_o,
  input  logic                             mem_gnt_i,
  output logic [AddrWidth-1:0]             mem_addr_o,
  output logic                             mem_we_o,
  output logic [DataWidth-1:0]             mem_wdata_o,
  output logic [StrbWidth-1:0]             mem_be_o,
  input  logic [DataWidth-1:0]             mem_rdata_i,
  output logic [31:0]                      conflict_cnt_o
);

  localparam int unsigned IdxWidth    = idx_width(NumReq);
  localparam int unsigned StarveWidth = starve_width(StarveLimit);

  typedef logic [IdxWidth-1:0]    idx_t;
  typedef logic [StarveWidth-1:0] starve_t;

  idx_t                    sel_idx;
  idx_t                    rr_q;
  idx_t                    lock_idx_q;
  logic                    lock_q;
  logic                    accept;
  starve_t [NumReq-1:0]    starve_q;
  rsp_track_t              track_in;
  rsp_track_t              track_out;

  // Priority: active lock, then lowest starving requester, then round-robin from rr_q.
  always_comb begin
    logic        found;
    int unsigned cand;
    sel_idx = '0;
    found   = 1'b0;
    cand    = 0;
    if (lock_q) begin
      sel_idx = lock_idx_q;
    end else begin
      for (int unsigned j = 0; j < NumReq; j++) begin
        if (!found && req_valid_i[j] && (starve_q[j] >= StarveWidth'(StarveLimit))) begin
          sel_idx = idx_t'(j);
          found   = 1'b1;
        end
      end
      for (int unsigned i = 0; i < NumReq; i++) begin
        cand = (int'(rr_q) + i) % NumReq;
        if (!found && req_valid_i[cand]) begin
          sel_idx = idx_t'(cand);
          found   = 1'b1;
        end
      end
    end
  end

  // Requests are masked while reset is held so nothing is accepted into a cleared pipe.
  assign mem_req_o = (|req_valid_i) & ~rst_i;
  assign accept    = mem_req_o & mem_gnt_i;

  always_comb begin
    for (int unsigned k = 0; k < NumReq; k++) begin
      req_ready_o[k] = accept && (sel_idx == idx_t'(k));
    end
  end

  assign mem_addr_o  = mem_req_o ? req_addr_i[sel_idx]  : '0;
  assign mem_we_o    = mem_req_o ? req_write_i[sel_idx] : 1'b0;
  assign mem_wdata_o = mem_req_o ? req_wdata_i[sel_idx] : '0;
  assign mem_be_o    = mem_req_o ? req_strb_i[sel_idx]  : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      rr_q       <= '0;
      starve_q   <= '0;
    end else begin
      if (mem_req_o && !mem_gnt_i) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel_idx;
      end else if (accept) begin
        lock_q <= 1'b0;
      end
      if (accept) begin
        rr_q <= (sel_idx == idx_t'(NumReq - 1)) ? '0 : sel_idx + 1'b1;
      end
      for (int unsigned j = 0; j < NumReq; j++) begin
        if (req_ready_o[j]) begin
          starve_q[j] <= '0;
        end else if (req_valid_i[j] && (starve_q[j] < StarveWidth'(StarveLimit))) begin
          starve_q[j] <= starve_q[j] + 1'b1;
        end
      end
    end
  end

  assign track_in.valid = accept;
  assign track_in.idx   = MaxIdxWidth'(sel_idx);

  snitch_tcdm_arb_rsp_tracker #(
    .Depth (MemoryResponseLatency)
  ) i_rsp_tracker (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .in_i  (track_in),
    .out_o (track_out)
  );

  always_comb begin
    for (int unsigned k = 0; k < NumReq; k++) begin
      rsp_valid_o[k] = track_out.valid && (track_out.idx == MaxIdxWidth'(k));
    end
  end

  assign rsp_rdata_o = mem_rdata_i;

`ifdef SNITCH_TCDM_ARB_STATS_EN
  logic [31:0] conflict_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      conflict_q <= '0;
    end else if (($countones(req_valid_i) >= 2) || (mem_req_o && !mem_gnt_i)) begin
      conflict_q <= conflict_q + 32'd1;
    end
  end

  assign conflict_cnt_o = conflict_q;
`else
  assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_snitch_tcdm_bank_arb.sv
// Directed bench: instance A (2 requesters, latency 1) and instance B (3 requesters, starve limit 2, latency 3).
module tb_snitch_tcdm_bank_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Instance A
  logic [1:0]       a_valid, a_ready, a_write, a_rsp_valid;
  logic [1:0][9:0]  a_addr;
  logic [1:0][63:0] a_wdata;
  logic [1:0][7:0]  a_strb;
  logic [63:0]      a_rsp_rdata, a_mem_wdata, a_mem_rdata;
  logic             a_mem_req, a_gnt, a_mem_we;
  logic [9:0]       a_mem_addr;
  logic [7:0]       a_mem_be;
  logic [31:0]      a_cnt;

  // Instance B
  logic [2:0]       b_valid, b_ready, b_write, b_rsp_valid;
  logic [2:0][9:0]  b_addr;
  logic [2:0][63:0] b_wdata;
  logic [2:0][7:0]  b_strb;
  logic [63:0]      b_rsp_rdata, b_mem_wdata, b_mem_rdata;
  logic             b_mem_req, b_gnt, b_mem_we;
  logic [9:0]       b_mem_addr;
  logic [7:0]       b_mem_be;
  logic [31:0]      b_cnt;

  snitch_tcdm_bank_arb #(
    .NumReq                (2),
    .AddrWidth             (10),
    .DataWidth             (64),
    .MemoryResponseLatency (1),
    .StarveLimit           (16)
  ) dut_a (
    .clk_i (clk), .rst_i (rst),
    .req_valid_i (a_valid), .req_ready_o (a_ready), .req_addr_i (a_addr),
    .req_write_i (a_write), .req_wdata_i (a_wdata), .req_strb_i (a_strb),
    .rsp_valid_o (a_rsp_valid), .rsp_rdata_o (a_rsp_rdata),
    .mem_req_o (a_mem_req), .mem_gnt_i (a_gnt), .mem_addr_o (a_mem_addr),
    .mem_we_o (a_mem_we), .mem_wdata_o (a_mem_wdata), .mem_be_o (a_mem_be),
    .mem_rdata_i (a_mem_rdata), .conflict_cnt_o (a_cnt)
  );

  snitch_tcdm_bank_arb #(
    .NumReq                (3),
    .AddrWidth             (10),
    .DataWidth             (64),
    .MemoryResponseLatency (3),
    .StarveLimit           (2)
  ) dut_b (
    .clk_i (clk), .rst_i (rst),
    .req_valid_i (b_valid), .req_ready_o (b_ready), .req_addr_i (b_addr),
    .req_write_i (b_write), .req_wdata_i (b_wdata), .req_strb_i (b_strb),
    .rsp_valid_o (b_rsp_valid), .rsp_rdata_o (b_rsp_rdata),
    .mem_req_o (b_mem_req), .mem_gnt_i (b_gnt), .mem_addr_o (b_mem_addr),
    .mem_we_o (b_mem_we), .mem_wdata_o (b_mem_wdata), .mem_be_o (b_mem_be),
    .mem_rdata_i (b_mem_rdata), .conflict_cnt_o (b_cnt)
  );

`ifdef SNITCH_TCDM_ARB_STATS_EN
  localparam logic [31:0] ExpCntA = 32'd8;
  localparam logic [31:0] ExpCntB = 32'd6;
`else
  localparam logic [31:0] ExpCntA = 32'd0;
  localparam logic [31:0] ExpCntB = 32'd0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] prev_g;
    logic [1:0] exp_g;

    rst = 1'b1;
    a_valid = '0; a_write = '0; a_addr = '0; a_wdata = '0; a_strb = '0; a_gnt = 1'b0; a_mem_rdata = '0;
    b_valid = '0; b_write = '0; b_addr = '0; b_wdata = '0; b_strb = '0; b_gnt = 1'b0; b_mem_rdata = '0;
    repeat (2) @(posedge clk);
    probe();
    chk("rst_a_mem_req", 64'(a_mem_req), 64'd0);
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    chk("rst_a_rsp", 64'(a_rsp_valid), 64'd0);
    chk("rst_b_rsp", 64'(b_rsp_valid), 64'd0);
    chk("rst_b_mem_addr", 64'(b_mem_addr), 64'd0);
    chk("rst_a_cnt", 64'(a_cnt), 64'd0);
    rst = 1'b0;
    advance();

    // Single read on requester 0
    a_valid = 2'b01; a_addr[0] = 10'h003; a_gnt = 1'b1;
    probe();
    chk("rd_ready", 64'(a_ready), 64'b01);
    chk("rd_mem_req", 64'(a_mem_req), 64'd1);
    chk("rd_mem_addr", 64'(a_mem_addr), 64'h003);
    chk("rd_mem_we", 64'(a_mem_we), 64'd0);
    advance();

    // Response for the read while requester 1 issues a write
    a_valid = 2'b10; a_write = 2'b10; a_addr[1] = 10'h155;
    a_wdata[1] = 64'h1111_2222_3333_4444; a_strb[1] = 8'hF0;
    a_mem_rdata = 64'hDEAD_BEEF_0123_4567;
    probe();
    chk("rd_rsp_valid", 64'(a_rsp_valid), 64'b01);
    chk("rd_rsp_rdata", a_rsp_rdata, 64'hDEAD_BEEF_0123_4567);
    chk("wr_ready", 64'(a_ready), 64'b10);
    chk("wr_mem_we", 64'(a_mem_we), 64'd1);
    chk("wr_mem_addr", 64'(a_mem_addr), 64'h155);
    chk("wr_mem_wdata", a_mem_wdata, 64'h1111_2222_3333_4444);
    chk("wr_mem_be", 64'(a_mem_be), 64'hF0);
    advance();

    // Round-robin: both valid, grants alternate starting at 0
    a_write = '0; a_addr[0] = 10'h010; a_addr[1] = 10'h020;
    prev_g = 2'b10;
    for (int i = 0; i < 4; i++) begin
      a_valid = 2'b11;
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      probe();
      chk("rr_ready", 64'(a_ready), 64'(exp_g));
      chk("rr_mem_addr", 64'(a_mem_addr), (i % 2 == 0) ? 64'h010 : 64'h020);
      chk("rr_rsp", 64'(a_rsp_valid), 64'(prev_g));
      prev_g = exp_g;
      advance();
    end
    a_valid = 2'b00;
    probe();
    chk("rr_rsp_last", 64'(a_rsp_valid), 64'b10);
    advance();

    // Lock-in: requester 1 stalled by the bank, requester 0 joins meanwhile
    a_valid = 2'b10; a_gnt = 1'b0;
    probe();
    chk("lock0_ready", 64'(a_ready), 64'd0);
    chk("lock0_mem_req", 64'(a_mem_req), 64'd1);
    chk("lock0_mem_addr", 64'(a_mem_addr), 64'h020);
    advance();
    a_valid = 2'b11;
    probe();
    chk("lock1_ready", 64'(a_ready), 64'd0);
    chk("lock1_mem_addr", 64'(a_mem_addr), 64'h020);
    advance();
    probe();
    chk("lock2_ready", 64'(a_ready), 64'd0);
    advance();
    a_gnt = 1'b1;
    probe();
    chk("lock_release_ready", 64'(a_ready), 64'b10);
    advance();
    a_valid = 2'b01;
    probe();
    chk("lock_next_ready", 64'(a_ready), 64'b01);
    chk("lock_rsp1", 64'(a_rsp_valid), 64'b10);
    advance();
    a_valid = 2'b00;
    probe();
    chk("lock_rsp0", 64'(a_rsp_valid), 64'b01);
    chk("a_conflict_cnt", 64'(a_cnt), 64'(ExpCntA));
    advance();

    // Latency 3: accepts 0,1,0 back to back, rr wraps from 2 to 0
    b_gnt = 1'b1; b_addr[0] = 10'h001; b_addr[1] = 10'h002; b_addr[2] = 10'h003;
    b_valid = 3'b001;
    probe();
    chk("lat_c0_ready", 64'(b_ready), 64'b001);
    chk("lat_c0_addr", 64'(b_mem_addr), 64'h001);
    advance();
    b_valid = 3'b010;
    probe();
    chk("lat_c1_ready", 64'(b_ready), 64'b010);
    chk("lat_c1_rsp", 64'(b_rsp_valid), 64'd0);
    advance();
    b_valid = 3'b001;
    probe();
    chk("lat_c2_ready_wrap", 64'(b_ready), 64'b001);
    chk("lat_c2_rsp", 64'(b_rsp_valid), 64'd0);
    advance();
    b_valid = 3'b000; b_mem_rdata = 64'h0000_0000_0000_00A5;
    probe();
    chk("lat_c3_rsp", 64'(b_rsp_valid), 64'b001);
    chk("lat_c3_rdata", b_rsp_rdata, 64'h0000_0000_0000_00A5);
    advance();
    probe();
    chk("lat_c4_rsp", 64'(b_rsp_valid), 64'b010);
    advance();
    probe();
    chk("lat_c5_rsp", 64'(b_rsp_valid), 64'b001);
    advance();
    probe();
    chk("lat_c6_rsp", 64'(b_rsp_valid), 64'd0);
    advance();

    // Starvation: stall under lock on 1 lets 0 and 2 reach the limit, then escalation overrides rr
    b_valid = 3'b111; b_gnt = 1'b0;
    probe();
    chk("stv_s0_ready", 64'(b_ready), 64'd0);
    chk("stv_s0_addr", 64'(b_mem_addr), 64'h002);
    advance();
    probe();
    chk("stv_s1_ready", 64'(b_ready), 64'd0);
    advance();
    b_gnt = 1'b1;
    probe();
    chk("stv_s2_lock_wins", 64'(b_ready), 64'b010);
    advance();
    probe();
    chk("stv_s3_escalate0", 64'(b_ready), 64'b001);
    advance();
    probe();
    chk("stv_s4_escalate2", 64'(b_ready), 64'b100);
    advance();
    b_valid = 3'b011;
    probe();
    chk("stv_s5_escalate1", 64'(b_ready), 64'b010);
    chk("stv_s5_rsp", 64'(b_rsp_valid), 64'b010);
    advance();
    b_valid = 3'b000;
    probe();
    chk("stv_s6_rsp", 64'(b_rsp_valid), 64'b001);
    advance();
    probe();
    chk("stv_s7_rsp", 64'(b_rsp_valid), 64'b100);
    advance();
    probe();
    chk("stv_s8_rsp", 64'(b_rsp_valid), 64'b010);
    chk("b_conflict_cnt", 64'(b_cnt), 64'(ExpCntB));
    advance();

    // Reset mid-flight: in-flight response must be dropped
    b_valid = 3'b001;
    probe();
    chk("rmf_accept", 64'(b_ready), 64'b001);
    advance();
    rst = 1'b1;
    #1;
    chk("rmf_in_rst_mem_req", 64'(b_mem_req), 64'd0);
    chk("rmf_in_rst_ready", 64'(b_ready), 64'd0);
    chk("rmf_in_rst_addr", 64'(b_mem_addr), 64'd0);
    chk("rmf_in_rst_rsp", 64'(b_rsp_valid), 64'd0);
    chk("rmf_in_rst_cnt_b", 64'(b_cnt), 64'd0);
    chk("rmf_in_rst_cnt_a", 64'(a_cnt), 64'd0);
    b_valid = 3'b000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      probe();
      chk("rmf_no_rsp", 64'(b_rsp_valid), 64'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
